// File: rtl/irq_stim_pkg.sv
// Shared constants for the irq stimulus generator: register map, ctrl bits, mode and LFSR setup.
// The LFSR items are only used when IRQ_STIM_JITTER_EN is defined.
package irq_stim_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_OVR    = 2'd2;
  localparam logic [1:0] REG_LFSR   = 2'd3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_BIT = 1;

  typedef enum logic {
    MODE_PULSE = 1'b0,
    MODE_LEVEL = 1'b1
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/irq_stim_chan.sv
// One programmable interrupt channel: period counter, pulse/level output, pending and overrun.
// With IRQ_STIM_JITTER_EN defined, an LFSR adds 0..15 cycles to each interval.
module irq_stim_chan
  import irq_stim_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 8191,
  parameter bit          DEF_EN     = 1'b0
`ifdef IRQ_STIM_JITTER_EN
  ,
  parameter int unsigned CH_IDX     = 0
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_we,
  input  logic             period_we,
  input  logic             ovr_we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             eoi,
  output logic             en,
  output logic             mode,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       ovr,
  output logic [15:0]      lfsr,
  output logic             irq
);

  localparam int unsigned CW = CNT_W + 1;

  logic [CNT_W:0]   cnt_q, cnt_d, cmp_val;
  logic [CNT_W-1:0] period_q, period_d;
  logic             en_q, en_d;
  mode_e            mode_q, mode_d;
  logic             pending_q, pending_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             irq_q, irq_d;
  logic             fire;

`ifdef IRQ_STIM_JITTER_EN
  logic [15:0] lfsr_q;

  // One extra bit keeps period + jitter from wrapping.
  assign cmp_val = {1'b0, period_q} + CW'(lfsr_q[3:0]);
  assign lfsr    = lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED + 16'(CH_IDX);
    end else if (fire) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end
`else
  assign cmp_val = {1'b0, period_q};
  assign lfsr    = '0;
`endif

  assign fire = en_q && (cnt_q == cmp_val);

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;

    if (en_q) cnt_d = fire ? '0 : cnt_q + CW'(1);

    if (mode_q == MODE_LEVEL) begin
      if (fire) begin
        // A same-cycle eoi is consumed by the new fire: pending stays set, no overrun.
        pending_d = 1'b1;
        if (pending_q && !eoi && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end else if (eoi) begin
        pending_d = 1'b0;
      end
    end

    if (ovr_we) ovr_d = '0;

    if (period_we) begin
      period_d = wdata;
      cnt_d    = '0;
    end

    if (ctrl_we) begin
      en_d   = wdata[CTRL_EN_BIT];
      mode_d = wdata[CTRL_MODE_BIT] ? MODE_LEVEL : MODE_PULSE;
      if (!en_d || mode_d != mode_q) pending_d = 1'b0;
      if (!en_d) cnt_d = '0;
    end

    irq_d = en_d && ((mode_d == MODE_LEVEL) ? pending_d : (fire && mode_q == MODE_PULSE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      period_q  <= DEF_PERIOD[CNT_W-1:0];
      en_q      <= DEF_EN;
      mode_q    <= MODE_PULSE;
      pending_q <= 1'b0;
      ovr_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
    end
  end

  assign en     = en_q;
  assign mode   = mode_q;
  assign period = period_q;
  assign ovr    = ovr_q;
  assign irq    = irq_q;

endmodule

// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: NUM_CH programmable channels behind a small register port.
// Define IRQ_STIM_JITTER_EN to add per-channel LFSR interval jitter (readable at reg3).
module irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned IRQ_BASE   = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 8191,
  parameter bit          DEF_EN     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic        cfg_re,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_rvalid,
  input  logic [31:0] eoi,
  output logic [31:0] irq
);

  logic [2:0] addr_ch;
  logic [1:0] addr_reg;
  logic       ch_ok;

  assign addr_ch  = cfg_addr[4:2];
  assign addr_reg = cfg_addr[1:0];
  assign ch_ok    = (32'(addr_ch) < NUM_CH);

  logic [NUM_CH-1:0] ch_en, ch_mode, ch_irq;
  logic [CNT_W-1:0]  ch_period [NUM_CH];
  logic [7:0]        ch_ovr    [NUM_CH];
  logic [15:0]       ch_lfsr   [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic sel;
    assign sel = cfg_we && (addr_ch == 3'(i));

    irq_stim_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_EN     (DEF_EN)
`ifdef IRQ_STIM_JITTER_EN
      ,
      .CH_IDX     (i)
`endif
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (sel && (addr_reg == REG_CTRL)),
      .period_we (sel && (addr_reg == REG_PERIOD)),
      .ovr_we    (sel && (addr_reg == REG_OVR)),
      .wdata     (cfg_wdata[CNT_W-1:0]),
      .eoi       (eoi[IRQ_BASE+i]),
      .en        (ch_en[i]),
      .mode      (ch_mode[i]),
      .period    (ch_period[i]),
      .ovr       (ch_ovr[i]),
      .lfsr      (ch_lfsr[i]),
      .irq       (ch_irq[i])
    );
  end

  logic             cur_en, cur_mode;
  logic [CNT_W-1:0] cur_period;
  logic [7:0]       cur_ovr;
  logic [15:0]      cur_lfsr;
  logic [31:0]      rdata_d;

  always_comb begin
    cur_en     = 1'b0;
    cur_mode   = 1'b0;
    cur_period = '0;
    cur_ovr    = '0;
    cur_lfsr   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr_ch == 3'(i)) begin
        cur_en     = ch_en[i];
        cur_mode   = ch_mode[i];
        cur_period = ch_period[i];
        cur_ovr    = ch_ovr[i];
        cur_lfsr   = ch_lfsr[i];
      end
    end

    // Read and write share cfg_addr, so a concurrent write always hits the register being read.
    rdata_d = '0;
    if (ch_ok) begin
      case (addr_reg)
        REG_CTRL: begin
          rdata_d = cfg_we ? {30'b0, cfg_wdata[CTRL_MODE_BIT], cfg_wdata[CTRL_EN_BIT]}
                           : {30'b0, cur_mode, cur_en};
        end
        REG_PERIOD: rdata_d = cfg_we ? 32'(cfg_wdata[CNT_W-1:0]) : 32'(cur_period);
        REG_OVR:    rdata_d = cfg_we ? 32'd0 : {24'b0, cur_ovr};
        default:    rdata_d = {16'b0, cur_lfsr};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
    end else begin
      cfg_rvalid <= cfg_re;
      if (cfg_re) cfg_rdata <= rdata_d;
    end
  end

  always_comb begin
    irq = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      irq[IRQ_BASE+i] = ch_irq[i];
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{cfg_wdata, eoi};

endmodule

// File: tb/tb_irq_stim_gen.sv
// Self-checking bench for irq_stim_gen: directed steps then random traffic against a
// fire-time arithmetic model.
module tb_irq_stim_gen;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned IRQ_BASE   = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DEF_PERIOD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_re = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] eoi = '0;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;
  logic [31:0] irq;

  int vectors = 0;
  int miscompares = 0;

  // Model: a channel fires on cycle cyc when (cyc - start) mod (period+1) == period.
  int m_en[NUM_CH], m_mode[NUM_CH], m_period[NUM_CH];
  int m_pending[NUM_CH], m_ovr[NUM_CH], m_start[NUM_CH];
  int cyc;
  logic [31:0] m_irq, m_rdata;
  logic        m_rvalid;

  always #5 clk = ~clk;

  irq_stim_gen #(
    .NUM_CH     (NUM_CH),
    .IRQ_BASE   (IRQ_BASE),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_EN     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_re     (cfg_re),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .eoi        (eoi),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit fires(input int c);
    if (m_en[c] == 0) return 1'b0;
    return ((cyc - m_start[c]) % (m_period[c] + 1)) == m_period[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 1; m_mode[c] = 0; m_period[c] = DEF_PERIOD;
      m_pending[c] = 0; m_ovr[c] = 0; m_start[c] = 0;
    end
    cyc = 0; m_irq = '0; m_rdata = '0; m_rvalid = 1'b0;
  endtask

  task automatic model_edge();
    int ch, rg, new_en, new_mode, old_mode, ack;
    bit f;
    ch = int'(cfg_addr[4:2]);
    rg = int'(cfg_addr[1:0]);
    if (cfg_re) begin
      m_rdata = '0;
      if (ch < NUM_CH) begin
        case (rg)
          0: m_rdata = cfg_we ? 32'(cfg_wdata[1:0]) : 32'(m_mode[ch] * 2 + m_en[ch]);
          1: m_rdata = cfg_we ? 32'(cfg_wdata[15:0]) : 32'(m_period[ch]);
          2: m_rdata = cfg_we ? 32'd0 : 32'(m_ovr[ch]);
          default: m_rdata = '0;
        endcase
      end
    end
    m_rvalid = cfg_re;
    m_irq = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      f = fires(c);
      old_mode = m_mode[c];
      ack = int'(eoi[IRQ_BASE+c]);
      if (old_mode == 1) begin
        if (f) begin
          if (m_pending[c] == 1 && ack == 0 && m_ovr[c] < 255) m_ovr[c]++;
          m_pending[c] = 1;
        end else if (ack == 1) begin
          m_pending[c] = 0;
        end
      end
      if (cfg_we && ch == c) begin
        case (rg)
          0: begin
            new_en = int'(cfg_wdata[0]);
            new_mode = int'(cfg_wdata[1]);
            if (new_en == 0 || new_mode != old_mode) m_pending[c] = 0;
            if (new_en == 1 && m_en[c] == 0) m_start[c] = cyc + 1;
            m_en[c] = new_en;
            m_mode[c] = new_mode;
          end
          1: begin
            m_period[c] = int'(cfg_wdata[15:0]);
            m_start[c] = cyc + 1;
          end
          2: m_ovr[c] = 0;
          default: ;
        endcase
      end
      if (m_mode[c] == 1) m_irq[IRQ_BASE+c] = (m_pending[c] == 1);
      else m_irq[IRQ_BASE+c] = f && old_mode == 0 && m_en[c] == 1;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", irq, m_irq);
    check("rvalid", 32'(cfg_rvalid), 32'(m_rvalid));
    check("rdata", cfg_rdata, m_rdata);
    cfg_we = 1'b0; cfg_re = 1'b0; eoi = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_irq", irq, 32'd0);
    check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    check("rst_rdata", cfg_rdata, 32'd0);
    reset = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0; eoi = '0;
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = {3'(ch), 2'(rg)};
    cfg_wdata = d;
    step();
  endtask

  task automatic rd(input int ch, input int rg);
    cfg_re = 1'b1;
    cfg_addr = {3'(ch), 2'(rg)};
    step();
  endtask

  task automatic wait_fire(input int c);
    int n = 0;
    while (!fires(c) && n < 40) begin
      step();
      n++;
    end
    check("fire_timeout", 32'(fires(c)), 32'd1);
  endtask

  initial begin
`ifndef IRQ_STIM_JITTER_EN
    do_reset();
    repeat (12) step();

    // Level mode with no eoi: irq stays high, overrun counts the extra fires.
    wr(0, 1, 9);
    wr(0, 0, 3);
    repeat (40) step();
    rd(0, 2);
    check("ovr_three", cfg_rdata, 32'd3);
    check("lvl_held", 32'(irq[4]), 32'd1);

    // eoi coinciding with a fire keeps pending; eoi elsewhere drops irq.
    wr(1, 1, 5);
    wr(1, 0, 3);
    wait_fire(1);
    step();
    wait_fire(1);
    eoi[5] = 1'b1;
    step();
    check("eoi_on_fire_irq", 32'(irq[5]), 32'd1);
    rd(1, 2);
    check("eoi_on_fire_ovr", cfg_rdata, 32'd0);
    eoi[5] = 1'b1;
    step();
    check("eoi_clear", 32'(irq[5]), 32'd0);

    // Overrun saturation at 255 and clear-on-write.
    wr(0, 2, 0);
    wr(0, 1, 0);
    repeat (300) step();
    rd(0, 2);
    check("ovr_sat", cfg_rdata, 32'd255);
    cfg_re = 1'b1;
    wr(0, 2, 32'hFFFF_FFFF);
    check("ovr_wr_first", cfg_rdata, 32'd0);
    rd(0, 2);
    check("ovr_cleared", cfg_rdata, 32'd0);

    // Disable while pending, then re-enable with period 4.
    check("pre_dis_irq", 32'(irq[4]), 32'd1);
    wr(0, 0, 2);
    check("dis_irq", 32'(irq[4]), 32'd0);
    wr(0, 1, 4);
    wr(0, 0, 3);
    repeat (4) step();
    check("reen_early", 32'(irq[4]), 32'd0);
    step();
    check("reen_fire", 32'(irq[4]), 32'd1);

    // Unimplemented channel.
    wr(5, 0, 3);
    wr(5, 1, 1);
    rd(5, 1);
    check("ch5_period", cfg_rdata, 32'd0);
    rd(5, 0);
    check("ch5_ctrl", cfg_rdata, 32'd0);
    repeat (10) step();

    // Reset while level pending and a read is issued.
    wait_fire(1);
    step();
    check("pend_before_rst", 32'(irq[5]), 32'd1);
    cfg_re = 1'b1;
    cfg_addr = 5'b00010;
    do_reset();
    rd(1, 2);
    check("ovr_after_rst", cfg_rdata, 32'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        eoi[4] = ($urandom_range(0, 5) == 0);
        eoi[5] = ($urandom_range(0, 5) == 0);
        cfg_addr = {3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 9) == 0) begin
          cfg_we = 1'b1;
          cfg_wdata = (cfg_addr[1:0] == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
        end
        cfg_re = ($urandom_range(0, 3) == 0);
        step();
      end
    end
`else
    begin
      int last, iv;
      do_reset();
      cfg_we = 1'b1; cfg_addr = 5'b00001; cfg_wdata = 32'd3;
      @(posedge clk); #1;
      cfg_addr = 5'b00000; cfg_wdata = 32'd1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      last = -1;
      for (int t = 0; t < 600; t++) begin
        @(posedge clk); #1;
        if (irq[4]) begin
          if (last >= 0) begin
            iv = t - last;
            check("jit_interval", 32'(iv >= 4 && iv <= 19), 32'd1);
          end
          last = t;
        end
      end
      cfg_re = 1'b1; cfg_addr = 5'b00011;
      @(posedge clk); #1;
      cfg_re = 1'b0;
      check("jit_lfsr_nz", 32'(cfg_rdata != 32'd0), 32'd1);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_stim_gen.md
Name: irq_stim_gen

Overview:
- Parametrised interrupt stimulus generator for the CPU simulation wrapper.
- Replaces fixed free-running-counter IRQ taps with NUM_CH independently programmable channels.
- Each channel has its own period, enable, pulse or level mode, EOI-acknowledged pending bit and overrun counter.
- Drives the 32-bit irq vector into the core; configured by the bench through a simple register port.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- IRQ_BASE, 4, irq bit driven by channel 0; channel i drives irq[IRQ_BASE+i]; IRQ_BASE+NUM_CH <= 32.
- CNT_W, 16, period/counter width.
- DEF_PERIOD, 8191, period loaded at reset.
- DEF_EN, 0, reset value of every channel's enable bit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cfg_we  in  1  register write strobe.
- cfg_re  in  1  register read strobe.
- cfg_addr  in  5  {ch[2:0], reg[1:0]}.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data, valid with cfg_rvalid.
- cfg_rvalid  out  1  one-cycle read-data valid.
- eoi  in  32  end-of-interrupt from core; bit IRQ_BASE+i acknowledges channel i.
- irq  out  32  interrupt vector; bits outside the channel range are tied 0.

Behaviour:
- Single clock; all state changes on posedge clk; reset is synchronous, active-high and wins over everything.
- Reset values: irq=0, cfg_rdata=0, cfg_rvalid=0, counters=0, pending=0, overrun=0, period=DEF_PERIOD, en=DEF_EN, mode=pulse.
- Register map per channel:
  - reg0 ctrl: bit0 en, bit1 mode (0 pulse, 1 level).
  - reg1 period: low CNT_W bits.
  - reg2 overrun: 8-bit, read-only; any write clears it.
  - reg3: reserved; reads 0, writes ignored.
- Writes to ch >= NUM_CH are ignored; reads of ch >= NUM_CH return 0.
- Reads:
  - cfg_re in cycle N gives cfg_rvalid=1 and cfg_rdata in cycle N+1.
  - cfg_rdata holds its value after that.
  - A same-cycle write to the same register is seen by the read (write-first).
- Counter:
  - While en=1, increments each cycle.
  - When counter==period it "fires" and wraps to 0, giving an interval of period+1 cycles; period=0 fires every cycle.
  - Writing reg1 or clearing en forces the counter to 0.
  - Clearing en also clears pending and drops irq the next cycle.
- Pulse mode: irq bit is registered and high for exactly 1 cycle, the cycle after the fire; eoi is ignored.
- Level mode:
  - A fire sets pending; irq bit = pending, registered, so it rises 1 cycle after the fire.
  - eoi bit high for one cycle clears pending; irq falls next cycle.
- Overrun:
  - Fire while pending=1 and no eoi in the same cycle: overrun increments, saturating at 255.
  - Fire and eoi in the same cycle: pending stays 1, no overrun.
  - Applies in level mode only.
- Mode change via a reg0 write: pending is cleared and the counter keeps running.
- Reset asserted mid-pending or mid-read: all state returns to reset values on the next edge; cfg_rvalid=0.

Optional Feature:
- Macro IRQ_STIM_JITTER_EN.
- Defined:
  - Each channel has a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 + i), stepped on every fire.
  - Effective compare value = period + lfsr[3:0], in CNT_W+1-bit arithmetic so it never wraps.
  - reg3 reads {16'b0, lfsr}.
- Undefined: no LFSR logic; compare value = period exactly; reg3 reads 0.

Decomposition:
- Package irq_stim_pkg holds:
  - register offsets: REG_CTRL=0, REG_PERIOD=1, REG_OVR=2, REG_LFSR=3;
  - ctrl bit positions;
  - mode enum: MODE_PULSE, MODE_LEVEL;
  - LFSR seed and tap constants.
- One sub-module, irq_stim_chan, instantiated NUM_CH times via generate; it holds counter, pending, overrun and the optional LFSR.
- Top level does address decode, the read mux and the irq vector assembly.

Test Plan:
- Reset default: DEF_EN=1, DEF_PERIOD=3, pulse mode -> irq[4] pulses 1 cycle wide every 4 cycles, first pulse 5 cycles after reset release; irq[5] same.
- Write ch0 period=9, level mode; hold eoi=0 -> irq[4] rises once and stays high; after 3 further fires reg2 reads 3, with cfg_rvalid 1 cycle after cfg_re.
- Level ch1, pulse eoi[5] in exactly the fire cycle -> irq[5] stays high and overrun stays 0; pulse eoi[5] in a non-fire cycle -> irq[5] low next cycle.
- Overrun saturation: period=0, level mode, no eoi for 300 cycles -> reg2 reads 255; write reg2 -> reads 0.
- Disable mid-pending: clear en while irq[4]=1 -> irq[4]=0 next cycle; re-enable -> first fire after period+1 cycles. Also: write ch=5 with NUM_CH=2 -> no effect; read returns 0.
- Assert reset while a level irq is pending and cfg_re is issued in the same cycle -> irq=0, cfg_rvalid=0, overrun=0 next cycle. With IRQ_STIM_JITTER_EN defined: intervals fall in [period+1, period+16] and reg3 reads nonzero.
